// File: rtl/tdpr_be_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : tdpr_be_pipe_if
// Description : Bus bundle for the two masters of tdpr_be_pipe. Carries the
//               per-port request/response signals, the collision flag and
//               the clear-sequencer busy flag.
// Revision    : 1.0  initial release
// ============================================================================
interface tdpr_be_pipe_if #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int BYTE_W    = 8
);
    localparam int NUM_BE = DATA_SIZE / BYTE_W;

    logic                 en_a;
    logic [NUM_BE-1:0]    we_a;
    logic [ADDR_SIZE-1:0] addr_a;
    logic [DATA_SIZE-1:0] din_a;
    logic [DATA_SIZE-1:0] dout_a;
    logic                 rvalid_a;

    logic                 en_b;
    logic [NUM_BE-1:0]    we_b;
    logic [ADDR_SIZE-1:0] addr_b;
    logic [DATA_SIZE-1:0] din_b;
    logic [DATA_SIZE-1:0] dout_b;
    logic                 rvalid_b;

    logic                 coll;
    logic                 init_busy;

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
        input  dout_a, rvalid_a, dout_b, rvalid_b, coll, init_busy
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
        output dout_a, rvalid_a, dout_b, rvalid_b, coll, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/tdpr_be_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tdpr_be_pipe
// Description : True dual-port synchronous RAM with byte write enables,
//               selectable same-port read-during-write mode, configurable
//               write-write collision winner, optional output register and
//               a one-cycle collision pulse.
//               Optional macro TDPR_INIT_CLEAR_EN adds a post-reset clear
//               sequencer that zeroes the array and blocks both ports.
// Revision    : 1.0  initial release
// ============================================================================
module tdpr_be_pipe #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int BYTE_W    = 8,
    parameter int RD_MODE   = 0,
    parameter int OUT_REG   = 0,
    parameter int COLL_PRIO = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    tdpr_be_pipe_if.slave bus
);
    localparam int NUM_BE = DATA_SIZE / BYTE_W;
    localparam int DEPTH  = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic                 ports_rdy;
    logic                 clr_we;
    logic [ADDR_SIZE-1:0] clr_addr;

    logic                 acc_a, acc_b, same_addr;
    logic [NUM_BE-1:0]    wa, wb, wa_eff, wb_eff;
    logic [DATA_SIZE-1:0] old_a, old_b, merge_a, merge_b;
    logic [DATA_SIZE-1:0] data_a_d, data_b_d;
    logic                 ld_a, ld_b, coll_d;

    logic [DATA_SIZE-1:0] data_a_q, data_b_q;
    logic                 dv_a_q, dv_b_q, coll_q;

    assign acc_a     = bus.en_a & ports_rdy;
    assign acc_b     = bus.en_b & ports_rdy;
    assign wa        = acc_a ? bus.we_a : '0;
    assign wb        = acc_b ? bus.we_b : '0;
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign old_a     = mem_q[bus.addr_a];
    assign old_b     = mem_q[bus.addr_b];

    // Arbitrate overlapping lanes, then build each port's post-write word
    always_comb begin
        wa_eff  = wa;
        wb_eff  = wb;
        merge_a = old_a;
        merge_b = old_b;
        for (int i = 0; i < NUM_BE; i++) begin
            if (same_addr && wa[i] && wb[i]) begin
                if (COLL_PRIO == 0) wb_eff[i] = 1'b0;
                else                wa_eff[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_BE; i++) begin
            if (wa_eff[i])
                merge_a[i*BYTE_W +: BYTE_W] = bus.din_a[i*BYTE_W +: BYTE_W];
            else if (same_addr && wb_eff[i])
                merge_a[i*BYTE_W +: BYTE_W] = bus.din_b[i*BYTE_W +: BYTE_W];
            if (wb_eff[i])
                merge_b[i*BYTE_W +: BYTE_W] = bus.din_b[i*BYTE_W +: BYTE_W];
            else if (same_addr && wa_eff[i])
                merge_b[i*BYTE_W +: BYTE_W] = bus.din_a[i*BYTE_W +: BYTE_W];
        end
    end

    // Sole writer of the array; lanes are already disjoint after arbitration
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[clr_addr] <= '0;
            end else begin
                for (int i = 0; i < NUM_BE; i++) begin
                    if (wa_eff[i])
                        mem_q[bus.addr_a][i*BYTE_W +: BYTE_W] <= bus.din_a[i*BYTE_W +: BYTE_W];
                    if (wb_eff[i])
                        mem_q[bus.addr_b][i*BYTE_W +: BYTE_W] <= bus.din_b[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // NO_CHANGE suppresses the data stage on writes; reads always load it.
    // The other port's write is never visible here: old_x is the pre-edge word.
    assign ld_a     = acc_a && ((wa == '0) || (RD_MODE != 2));
    assign ld_b     = acc_b && ((wb == '0) || (RD_MODE != 2));
    assign data_a_d = ((wa != '0) && (RD_MODE == 1)) ? merge_a : old_a;
    assign data_b_d = ((wb != '0) && (RD_MODE == 1)) ? merge_b : old_b;
    assign coll_d   = acc_a && acc_b && same_addr && (|(wa & wb));

    // First read stage plus the collision pulse, which never goes through OUT_REG
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
            dv_a_q   <= 1'b0;
            dv_b_q   <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            dv_a_q <= ld_a;
            dv_b_q <= ld_b;
            if (ld_a) data_a_q <= data_a_d;
            if (ld_b) data_b_q <= data_b_d;
            coll_q <= coll_d;
        end
    end

    assign bus.coll = coll_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_SIZE-1:0] out_a_q, out_b_q;
            logic                 orv_a_q, orv_b_q;

            // Second stage: hold dout between valid beats, forward the strobe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                    orv_a_q <= 1'b0;
                    orv_b_q <= 1'b0;
                end else begin
                    orv_a_q <= dv_a_q;
                    orv_b_q <= dv_b_q;
                    if (dv_a_q) out_a_q <= data_a_q;
                    if (dv_b_q) out_b_q <= data_b_q;
                end
            end

            assign bus.dout_a   = out_a_q;
            assign bus.dout_b   = out_b_q;
            assign bus.rvalid_a = orv_a_q;
            assign bus.rvalid_b = orv_b_q;
        end else begin : g_out_direct
            assign bus.dout_a   = data_a_q;
            assign bus.dout_b   = data_b_q;
            assign bus.rvalid_a = dv_a_q;
            assign bus.rvalid_b = dv_b_q;
        end
    endgenerate

`ifdef TDPR_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } clr_state_t;

    localparam logic [ADDR_SIZE:0] LAST_ADDR = {1'b0, {ADDR_SIZE{1'b1}}};

    clr_state_t         state_q;
    logic [ADDR_SIZE:0] cnt_q;
    logic               busy_q;

    // Clear sequencer: one address per cycle, restarts from 0 on every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ports_rdy     = (state_q == S_DONE);
    assign clr_we        = (state_q == S_CLEAR);
    assign clr_addr      = cnt_q[ADDR_SIZE-1:0];
    assign bus.init_busy = busy_q;
`else
    assign ports_rdy     = 1'b1;
    assign clr_we        = 1'b0;
    assign clr_addr      = '0;
    assign bus.init_busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdpr_be_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdpr_be_pipe
// Description : Self-checking bench. Three instances share one stimulus:
//               dut0 RD_MODE=0/OUT_REG=0/COLL_PRIO=0, dut1 RD_MODE=1/
//               OUT_REG=1/COLL_PRIO=1, dut2 RD_MODE=2/OUT_REG=0/COLL_PRIO=0.
//               A word-level model predicts every output each cycle; directed
//               literal checks pin the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tdpr_be_pipe;
    localparam int DEPTH = 256;
`ifdef TDPR_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int INIT_WAIT = CLR ? DEPTH + 2 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;
    logic        run = 1'b0;

    logic [31:0] dout_a_w [3];
    logic [31:0] dout_b_w [3];
    logic        rva_w [3], rvb_w [3], coll_w [3], busy_w [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tdpr_be_pipe_if #(.ADDR_SIZE(8), .DATA_SIZE(32), .BYTE_W(8)) bus ();
        assign bus.en_a   = en_a;
        assign bus.we_a   = we_a;
        assign bus.addr_a = addr_a;
        assign bus.din_a  = din_a;
        assign bus.en_b   = en_b;
        assign bus.we_b   = we_b;
        assign bus.addr_b = addr_b;
        assign bus.din_b  = din_b;
        tdpr_be_pipe #(
            .ADDR_SIZE(8), .DATA_SIZE(32), .BYTE_W(8),
            .RD_MODE(g), .OUT_REG(g == 1 ? 1 : 0), .COLL_PRIO(g == 1 ? 1 : 0)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign dout_a_w[g] = bus.dout_a;
        assign dout_b_w[g] = bus.dout_b;
        assign rva_w[g]    = bus.rvalid_a;
        assign rvb_w[g]    = bus.rvalid_b;
        assign coll_w[g]   = bus.coll;
        assign busy_w[g]   = bus.init_busy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm     [3][DEPTH];
    logic [31:0] e_dout [3][2];
    logic        e_rv   [3][2];
    logic        s1v    [3][2];
    logic [31:0] s1d    [3][2];
    logic        e_coll [3];
    logic        e_busy = 1'b0;
    int          ph = 0;
    logic        m_blk, m_ea, m_eb;
    logic [3:0]  m_wa, m_wb;
    logic [31:0] m_olda, m_oldb;

    function automatic int rdm(input int k);
        return k;
    endfunction
    function automatic bit oreg(input int k);
        return k == 1;
    endfunction
    function automatic bit bwins(input int k);
        return k == 1;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    task automatic res(input int k, input int p, input logic en, input logic [3:0] w,
                       input logic [31:0] oldw, input logic [31:0] neww);
        logic        v;
        logic [31:0] d;
        v = en;
        d = oldw;
        if (en && w != 4'h0) begin
            if (rdm(k) == 2)      v = 1'b0;
            else if (rdm(k) == 1) d = neww;
        end
        if (oreg(k)) begin
            e_rv[k][p] = s1v[k][p];
            if (s1v[k][p]) e_dout[k][p] = s1d[k][p];
            s1v[k][p] = v;
            s1d[k][p] = d;
        end else begin
            e_rv[k][p] = v;
            if (v) e_dout[k][p] = d;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph     = 0;
            e_busy = 1'b0;
            for (int k = 0; k < 3; k++) begin
                e_coll[k] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    e_dout[k][p] = '0;
                    e_rv[k][p]   = 1'b0;
                    s1v[k][p]    = 1'b0;
                    s1d[k][p]    = '0;
                end
            end
        end else begin
            if (ph < DEPTH + 2) ph++;
            m_blk = CLR && (ph <= DEPTH + 1);
            m_ea  = en_a && !m_blk;
            m_eb  = en_b && !m_blk;
            m_wa  = m_ea ? we_a : 4'h0;
            m_wb  = m_eb ? we_b : 4'h0;
            for (int k = 0; k < 3; k++) begin
                m_olda = mm[k][addr_a];
                m_oldb = mm[k][addr_b];
                // loser first, winner overwrites shared lanes
                if (bwins(k)) begin
                    mm[k][addr_a] = lanes(mm[k][addr_a], din_a, m_wa);
                    mm[k][addr_b] = lanes(mm[k][addr_b], din_b, m_wb);
                end else begin
                    mm[k][addr_b] = lanes(mm[k][addr_b], din_b, m_wb);
                    mm[k][addr_a] = lanes(mm[k][addr_a], din_a, m_wa);
                end
                res(k, 0, m_ea, m_wa, m_olda, mm[k][addr_a]);
                res(k, 1, m_eb, m_wb, m_oldb, mm[k][addr_b]);
                e_coll[k] = m_ea && m_eb && (addr_a == addr_b) && ((m_wa & m_wb) != 4'h0);
            end
            if (CLR && ph == DEPTH + 1)
                for (int k = 0; k < 3; k++)
                    for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
            e_busy = CLR && (ph >= 1) && (ph <= DEPTH);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("dut%0d dout_a", k),    dout_a_w[k], e_dout[k][0]);
                chk($sformatf("dut%0d rvalid_a", k),  {31'b0, rva_w[k]},  {31'b0, e_rv[k][0]});
                chk($sformatf("dut%0d dout_b", k),    dout_b_w[k], e_dout[k][1]);
                chk($sformatf("dut%0d rvalid_b", k),  {31'b0, rvb_w[k]},  {31'b0, e_rv[k][1]});
                chk($sformatf("dut%0d coll", k),      {31'b0, coll_w[k]}, {31'b0, e_coll[k]});
                chk($sformatf("dut%0d init_busy", k), {31'b0, busy_w[k]}, {31'b0, e_busy});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic e, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        en_a = e; we_a = w; addr_a = a; din_a = d;
    endtask

    task automatic set_b(input logic e, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        en_b = e; we_b = w; addr_b = a; din_b = d;
    endtask

    task automatic idle();
        set_a(1'b0, 4'h0, 8'h00, 32'h0);
        set_b(1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (3) tick();
        run = 1'b1;
        chk("reset dout_a", dout_a_w[0], 32'h0);
        chk("reset rvalid_b", {31'b0, rvb_w[1]}, 32'h0);
        chk("reset coll", {31'b0, coll_w[0]}, 32'h0);
        rst = 1'b0;
        repeat (INIT_WAIT) tick();

        // basic write then cross-port read, both latencies
        set_a(1'b1, 4'hF, 8'h10, 32'hDEADBEEF); tick();
        idle(); set_b(1'b1, 4'h0, 8'h10, 32'h0); tick();
        chk("rd lat1 data", dout_b_w[0], 32'hDEADBEEF);
        chk("rd lat1 rvalid", {31'b0, rvb_w[0]}, 32'h1);
        chk("rd lat2 early rvalid", {31'b0, rvb_w[1]}, 32'h0);
        idle(); tick();
        chk("rd lat2 data", dout_b_w[1], 32'hDEADBEEF);
        chk("rd lat2 rvalid", {31'b0, rvb_w[1]}, 32'h1);

        // byte lanes
        set_a(1'b1, 4'hF, 8'h20, 32'h11223344); tick();
        set_a(1'b1, 4'h5, 8'h20, 32'hAABBCCDD); tick();
        set_a(1'b1, 4'h0, 8'h20, 32'h0); tick();
        chk("byte lanes", dout_a_w[0], 32'h11BB33DD);

        // same-port read-during-write
        set_a(1'b1, 4'hF, 8'h05, 32'h1); tick();
        set_a(1'b1, 4'h0, 8'h05, 32'h0); tick();
        set_a(1'b1, 4'hF, 8'h05, 32'h2); tick();
        chk("rmw read-first data", dout_a_w[0], 32'h1);
        chk("rmw read-first rvalid", {31'b0, rva_w[0]}, 32'h1);
        chk("rmw no-change rvalid", {31'b0, rva_w[2]}, 32'h0);
        chk("rmw no-change data", dout_a_w[2], 32'h1);
        idle(); tick();
        chk("rmw write-first data", dout_a_w[1], 32'h2);

        // write-write collision with overlapping lane 1
        set_a(1'b1, 4'hF, 8'h07, 32'h0); tick();
        set_a(1'b1, 4'h3, 8'h07, 32'h000000AA);
        set_b(1'b1, 4'h6, 8'h07, 32'hBBBBBBBB); tick();
        chk("coll pulse prio A", {31'b0, coll_w[0]}, 32'h1);
        chk("coll pulse prio B", {31'b0, coll_w[1]}, 32'h1);
        idle(); tick();
        chk("coll one cycle", {31'b0, coll_w[0]}, 32'h0);
        set_a(1'b1, 4'h0, 8'h07, 32'h0); tick();
        idle(); tick();
        chk("coll word prio A", dout_a_w[0], 32'h00BB00AA);
        chk("coll word prio B", dout_a_w[1], 32'h00BBBBAA);
        // disjoint lanes on the same address: no pulse
        set_a(1'b1, 4'h1, 8'h07, 32'h00000011);
        set_b(1'b1, 4'h2, 8'h07, 32'h00002200); tick();
        chk("no overlap no coll", {31'b0, coll_w[0]}, 32'h0);

        // cross-port read during write
        set_a(1'b1, 4'hF, 8'h03, 32'h55); set_b(1'b0, 4'h0, 8'h00, 32'h0); tick();
        set_a(1'b1, 4'hF, 8'h03, 32'h66); set_b(1'b1, 4'h0, 8'h03, 32'h0); tick();
        idle(); tick();
        chk("xport old lat1", dout_b_w[0], 32'h55);
        chk("xport old write-first", dout_b_w[1], 32'h55);
        set_b(1'b1, 4'h0, 8'h03, 32'h0); tick();
        chk("xport new", dout_b_w[0], 32'h66);

        // back-to-back traffic on both ports
        for (int i = 0; i < 8; i++) begin
            set_a(1'b0, 4'h0, 8'h00, 32'h0);
            set_b(1'b1, 4'hF, 8'(8'h40 + i), 32'h100 + i * 32'h01010101); tick();
        end
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 4'h0, 8'(8'h40 + i), 32'h0);
            set_b(1'b1, 4'h0, 8'(8'h47 - i), 32'h0); tick();
            chk($sformatf("b2b read %0d", i), dout_a_w[0], 32'h100 + i * 32'h01010101);
        end

        // reset in the middle of a read; write on the reset edge is dropped
        idle(); set_b(1'b1, 4'h0, 8'h10, 32'h0); tick();
        chk("pre-reset read", dout_b_w[0], 32'hDEADBEEF);
        rst = 1'b1;
        set_b(1'b0, 4'h0, 8'h00, 32'h0);
        set_a(1'b1, 4'hF, 8'h10, 32'h12345678);
        #1;
        chk("async reset dout", dout_b_w[0], 32'h0);
        chk("async reset rvalid", {31'b0, rvb_w[0]}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        idle();
        repeat (INIT_WAIT) tick();
        set_b(1'b1, 4'h0, 8'h10, 32'h0); tick();
        chk("write on reset edge dropped", dout_b_w[0], CLR ? 32'h0 : 32'hDEADBEEF);
        idle(); tick();

`ifdef TDPR_INIT_CLEAR_EN
        // write while busy is ignored; reset mid-clear restarts the clear
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("clear busy", {31'b0, busy_w[0]}, 32'h1);
        set_a(1'b1, 4'hF, 8'h30, 32'hFFFFFFFF); tick();
        idle(); repeat (8) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("clear done", {31'b0, busy_w[0]}, 32'h0);
        set_a(1'b1, 4'h0, 8'h30, 32'h0); tick();
        chk("cleared word", dout_a_w[0], 32'h0);
        idle(); tick();
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tdpr_be_pipe.md
Name: tdpr_be_pipe

Overview:
Parametrised true dual-port synchronous RAM, successor to the team's basic 8x8 true dual-port RAM. Adds per-byte write enables, a selectable same-port read-during-write mode, a configurable cross-port collision winner, an optional output pipeline register with read-valid strobes, and a collision flag. It sits between two independent masters that share one clock, for example a DMA engine and a CPU-side bus bridge.

Parameters:
ADDR_SIZE, 8, address width; depth = 1 << ADDR_SIZE words
DATA_SIZE, 32, word width; must be a multiple of BYTE_W
BYTE_W, 8, bits per write-enable lane; NUM_BE = DATA_SIZE / BYTE_W
RD_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new merged data), 2 = NO_CHANGE (dout and rvalid untouched on write)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
COLL_PRIO, 0, winner of a write-write collision: 0 = port A, 1 = port B

Ports:
clk  in  1  single clock for both ports
rst  in  1  asynchronous, active-high reset
en_a  in  1  port A access enable
we_a  in  NUM_BE  port A byte write enables (all zero = read)
addr_a  in  ADDR_SIZE  port A address
din_a  in  DATA_SIZE  port A write data
dout_a  out  DATA_SIZE  port A read data
rvalid_a  out  1  port A dout updated this cycle
en_b, we_b, addr_b, din_b, dout_b, rvalid_b: same as the port A signals, for port B
coll  out  1  one-cycle pulse: write-write collision occurred
init_busy  out  1  RAM clear sequencer active (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): dout_a/b = 0, rvalid_a/b = 0, coll = 0, pipeline stages = 0. RAM contents are not cleared unless the Optional Feature is compiled in.
- When en_x = 0: no access. dout_x holds its value (never Z). rvalid_x = 0.
- Write, en_x = 1 and we_x != 0: each byte lane i with we_x[i] = 1 takes din_x lane i at the clk edge. Other lanes keep their contents.
- Read, en_x = 1 and we_x = 0: the data stage captures ram[addr_x]. rvalid_x is asserted with dout_x, 1 cycle later (OUT_REG = 0) or 2 cycles later (OUT_REG = 1). Back-to-back reads are accepted every cycle.
- Write with RD_MODE = 0: dout gets the pre-write word. RD_MODE = 1: dout gets the post-write merged word. In both modes rvalid is asserted as for a read. RD_MODE = 2: the data stage is not loaded and rvalid stays 0.
- Cross-port, same address, one port writing and the other reading: the reader gets the old word (read-first across ports, in every RD_MODE).
- Write-write collision, both enabled and writing the same address:
  - Lanes enabled on both ports take the data of the COLL_PRIO winner.
  - Lanes enabled on only one port take that port's data.
  - If any lane overlaps, coll pulses high for exactly 1 cycle, on the cycle after the access; this timing is independent of OUT_REG. No overlap means no coll pulse.
- Each port's own dout/rvalid follows RD_MODE, using the final merged word for WRITE_FIRST.
- The RAM array is written from a single always block, with collision resolution done before the write. There are no multiple drivers.
- Reset asserted mid-read: the in-flight rvalid is dropped and dout goes to 0. RAM writes on the reset edge are suppressed.
- Addresses do not wrap: every address is in range by construction.

Optional Feature:
- Macro TDPR_INIT_CLEAR_EN.
- Defined:
  - After rst deasserts, FSM IDLE -> CLEAR -> DONE. CLEAR writes 0 to address 0..(1<<ADDR_SIZE)-1, one address per cycle, using an ADDR_SIZE+1-bit counter. It then enters DONE and stays there until the next rst.
  - init_busy = 1 during CLEAR, which lasts exactly 1<<ADDR_SIZE cycles.
  - Port requests are ignored while busy: rvalid = 0, no writes.
  - Reset mid-CLEAR restarts the clear from address 0.
- Not defined: there is no FSM, init_busy is tied 0, and the ports are usable on the first edge after reset.

Test Plan:
- Defaults: A writes 0xDEADBEEF to addr 0x10 with we_a = 4'hF, then B reads 0x10 -> dout_b = 0xDEADBEEF and rvalid_b high 1 cycle after the read; with OUT_REG = 1, 2 cycles after.
- Byte lanes: addr 0x20 holds 0x11223344; A writes din = 0xAABBCCDD with we_a = 4'b0101 -> next read = 0x11BB33DD.
- Same-port RMW: addr 5 holds 0x1; A writes 0x2. RD_MODE = 0 -> dout_a = 0x1, rvalid 1. RD_MODE = 1 -> 0x2. RD_MODE = 2 -> dout_a unchanged, rvalid_a = 0.
- Collision: COLL_PRIO = 0; A writes 0x000000AA with we = 4'b0011, B writes 0xBBBBBBBB with we = 4'b0110, both to addr 7 -> word = 0x00BB00AA over prior 0; coll = 1 for one cycle. Repeat with COLL_PRIO = 1 -> 0x00BBBBAA.
- Cross-port read during write: addr 3 holds 0x55; A writes 0x66 while B reads addr 3 in the same cycle -> dout_b = 0x55; a later read returns 0x66.
- TDPR_INIT_CLEAR_EN, ADDR_SIZE = 4: pulse rst -> init_busy high for 16 cycles; a write attempt is ignored; all 16 reads return 0. Assert rst at cycle 8 -> init_busy goes high for 16 more cycles.
